dti_fifo_async_2port_mem_par: RTL and testbench

// Two-port storage array for dti async FIFOs: byte-enable writes in wr_clk domain, optional registered read in rd_clk domain,
// per-byte even parity with error injection, single-cycle array clear and a saturating parity-error counter.

---
 rtl/dti_fifo_async_2port_mem_par.sv | 142 ++++++++++++++
 tb/tb_dti_fifo_async_2port_mem_par.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dti_fifo_async_2port_mem_par.sv
// Two-port storage array for dti async FIFOs.
// Byte-enable writes on wr_clk, optional registered read on rd_clk,
// per-byte even parity with injection hook, single-cycle clear and a
// saturating parity-error counter. No CDC synchronisers: the FIFO pointer
// logic guarantees entry stability across clocks.
module dti_fifo_async_2port_mem_par #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 4,
  parameter  int DEPTH      = 16,
  parameter  int PARITY_EN  = 1,
  parameter  int RD_REG     = 1,
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  wr_clk,
  input  logic                  wr_reset_n,
  input  logic                  rd_clk,
  input  logic                  rd_reset_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_din,
  input  logic [BE_WIDTH-1:0]   wr_be,
  input  logic [BE_WIDTH-1:0]   wr_par_inj,
  input  logic                  wr_clr,
  output logic                  wr_addr_err,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_dout,
  output logic                  rd_dout_vld,
  output logic [BE_WIDTH-1:0]   rd_par_err,
  output logic                  rd_addr_err,
  output logic [7:0]            rd_err_cnt,
  input  logic                  rd_err_cnt_clr
);

  if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH < 8) begin : g_bad_data_width
    $error("DATA_WIDTH must be a positive multiple of 8");
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("DEPTH must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH");
  end

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [BE_WIDTH-1:0]   par [DEPTH];

  logic                  wr_in_range;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [BE_WIDTH-1:0]   rd_par_word;
  logic [BE_WIDTH-1:0]   rd_perr_c;
  logic                  rd_aerr_c;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);

  // Write port: clear beats write; byte-lane updates with stored parity.
  always_ff @(posedge wr_clk or negedge wr_reset_n) begin
    if (!wr_reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
        par[i] <= '0;
      end
      wr_addr_err <= 1'b0;
    end else if (wr_clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
        par[i] <= '0;
      end
      wr_addr_err <= 1'b0;
    end else begin
      wr_addr_err <= wr_en && !wr_in_range;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_en && (wr_addr == ADDR_WIDTH'(i))) begin
          for (int unsigned b = 0; b < BE_WIDTH; b++) begin
            if (wr_be[b]) begin
              mem[i][8*b +: 8] <= wr_din[8*b +: 8];
              par[i][b]        <= (PARITY_EN != 0) ?
                                  ((^wr_din[8*b +: 8]) ^ wr_par_inj[b]) : 1'b0;
            end
          end
        end
      end
    end
  end

  // Read mux and parity check; out-of-range addresses read as clean zero.
  always_comb begin
    rd_word     = '0;
    rd_par_word = '0;
    rd_perr_c   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (rd_addr == ADDR_WIDTH'(i)) begin
        rd_word     = mem[i];
        rd_par_word = par[i];
      end
    end
    for (int unsigned b = 0; b < BE_WIDTH; b++) begin
      rd_perr_c[b] = (PARITY_EN != 0) && (^{rd_word[8*b +: 8], rd_par_word[b]});
    end
    rd_aerr_c = !({1'b0, rd_addr} < DEPTH_L);
  end

  if (RD_REG != 0) begin : g_rd_reg
    // Registered read stage: data holds when idle, flags clear.
    always_ff @(posedge rd_clk or negedge rd_reset_n) begin
      if (!rd_reset_n) begin
        rd_dout     <= '0;
        rd_dout_vld <= 1'b0;
        rd_par_err  <= '0;
        rd_addr_err <= 1'b0;
      end else begin
        rd_dout_vld <= rd_en;
        rd_par_err  <= rd_en ? rd_perr_c : '0;
        rd_addr_err <= rd_en && rd_aerr_c;
        if (rd_en) begin
          rd_dout <= rd_word;
        end
      end
    end
  end else begin : g_rd_comb
    // Combinational read: flags qualified by rd_en.
    always_comb begin
      rd_dout     = rd_word;
      rd_dout_vld = rd_en;
      rd_par_err  = rd_en ? rd_perr_c : '0;
      rd_addr_err = rd_en && rd_aerr_c;
    end
  end

  // Saturating count of presented reads carrying any parity error.
  always_ff @(posedge rd_clk or negedge rd_reset_n) begin
    if (!rd_reset_n) begin
      rd_err_cnt <= '0;
    end else if (rd_err_cnt_clr) begin
      rd_err_cnt <= '0;
    end else if ((PARITY_EN != 0) && rd_dout_vld && (|rd_par_err) &&
                 (rd_err_cnt != 8'hFF)) begin
      rd_err_cnt <= rd_err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_dti_fifo_async_2port_mem_par.sv
// Scoreboard bench: instance a (default, registered read) and instance b
// (DEPTH=12, combinational read), both clocked from one clock so that
// read-before-write on a shared clock can be exercised.
module tb_dti_fifo_async_2port_mem_par;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  pe;
    logic        ae;
    int unsigned cy;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic wr_reset_n, rd_reset_n;

  logic        wr_en, wr_clr, wr_addr_err, rd_en, rd_dout_vld, rd_addr_err, rd_err_cnt_clr;
  logic [3:0]  wr_addr, rd_addr, wr_be, wr_par_inj, rd_par_err;
  logic [31:0] wr_din, rd_dout;
  logic [7:0]  rd_err_cnt;

  logic        b_wr_en, b_wr_clr, b_wr_addr_err, b_rd_en, b_rd_dout_vld, b_rd_addr_err, b_rd_err_cnt_clr;
  logic [3:0]  b_wr_addr, b_rd_addr, b_wr_be, b_wr_par_inj, b_rd_par_err;
  logic [31:0] b_wr_din, b_rd_dout;
  logic [7:0]  b_rd_err_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  exp_t qa[$];
  exp_t qb[$];

  dti_fifo_async_2port_mem_par u_a (
    .wr_clk(clk), .wr_reset_n(wr_reset_n), .rd_clk(clk), .rd_reset_n(rd_reset_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din), .wr_be(wr_be),
    .wr_par_inj(wr_par_inj), .wr_clr(wr_clr), .wr_addr_err(wr_addr_err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(rd_dout), .rd_dout_vld(rd_dout_vld),
    .rd_par_err(rd_par_err), .rd_addr_err(rd_addr_err), .rd_err_cnt(rd_err_cnt),
    .rd_err_cnt_clr(rd_err_cnt_clr)
  );

  dti_fifo_async_2port_mem_par #(.DEPTH(12), .RD_REG(0)) u_b (
    .wr_clk(clk), .wr_reset_n(wr_reset_n), .rd_clk(clk), .rd_reset_n(rd_reset_n),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_din(b_wr_din), .wr_be(b_wr_be),
    .wr_par_inj(b_wr_par_inj), .wr_clr(b_wr_clr), .wr_addr_err(b_wr_addr_err),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_dout(b_rd_dout), .rd_dout_vld(b_rd_dout_vld),
    .rd_par_err(b_rd_par_err), .rd_addr_err(b_rd_addr_err), .rd_err_cnt(b_rd_err_cnt),
    .rd_err_cnt_clr(b_rd_err_cnt_clr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for instance a: registered output, one cycle after issue.
  always @(negedge clk) begin
    exp_t e;
    if (rd_dout_vld === 1'b1) begin
      if (qa.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected_vld: got vld=1 expected no pending read (t=%0t)", $time);
      end else begin
        e = qa.pop_front();
        chk("a_dout", rd_dout, e.d);
        chk("a_par_err", rd_par_err, e.pe);
        chk("a_addr_err", rd_addr_err, e.ae);
        chk("a_latency_cycle", cyc, e.cy);
      end
    end
  end

  // Monitor for instance b: combinational output, same cycle as issue.
  always @(negedge clk) begin
    exp_t e;
    if (b_rd_dout_vld === 1'b1) begin
      if (qb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_vld: got vld=1 expected no pending read (t=%0t)", $time);
      end else begin
        e = qb.pop_front();
        chk("b_dout", b_rd_dout, e.d);
        chk("b_par_err", b_rd_par_err, e.pe);
        chk("b_addr_err", b_rd_addr_err, e.ae);
        chk("b_latency_cycle", cyc, e.cy);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_a(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be, input logic [3:0] inj);
    wr_en = 1'b1; wr_addr = a; wr_din = d; wr_be = be; wr_par_inj = inj;
    step();
    wr_en = 1'b0; wr_par_inj = '0;
  endtask

  task automatic rd_a(input logic [3:0] a, input logic [31:0] ed, input logic [3:0] epe, input logic eae);
    rd_en = 1'b1; rd_addr = a;
    qa.push_back('{d: ed, pe: epe, ae: eae, cy: cyc + 1});
    step();
    rd_en = 1'b0;
  endtask

  task automatic wr_b(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be, input logic [3:0] inj);
    b_wr_en = 1'b1; b_wr_addr = a; b_wr_din = d; b_wr_be = be; b_wr_par_inj = inj;
    step();
    b_wr_en = 1'b0; b_wr_par_inj = '0;
  endtask

  task automatic rd_b(input logic [3:0] a, input logic [31:0] ed, input logic [3:0] epe, input logic eae);
    b_rd_en = 1'b1; b_rd_addr = a;
    qb.push_back('{d: ed, pe: epe, ae: eae, cy: cyc});
    step();
    b_rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wr_reset_n = 1'b0; rd_reset_n = 1'b0;
    wr_en = 0; wr_clr = 0; wr_addr = '0; wr_din = '0; wr_be = '0; wr_par_inj = '0;
    rd_en = 0; rd_addr = '0; rd_err_cnt_clr = 0;
    b_wr_en = 0; b_wr_clr = 0; b_wr_addr = '0; b_wr_din = '0; b_wr_be = '0; b_wr_par_inj = '0;
    b_rd_en = 0; b_rd_addr = '0; b_rd_err_cnt_clr = 0;

    #2;
    chk("reset_dout", rd_dout, 0);
    chk("reset_vld", rd_dout_vld, 0);
    chk("reset_err_cnt", rd_err_cnt, 0);
    chk("reset_wr_addr_err", wr_addr_err, 0);
    #10;
    wr_reset_n = 1'b1; rd_reset_n = 1'b1;
    step();

    // 1: all entries read zero and clean after reset
    for (int i = 0; i < 16; i++) rd_a(4'(i), 32'h0, 4'h0, 1'b0);

    // 2: byte-enable merge, and wr_be=0 is a no-op
    wr_a(4'd3, 32'hAABBCCDD, 4'b1111, 4'b0000);
    wr_a(4'd3, 32'h11223344, 4'b0101, 4'b0000);
    rd_a(4'd3, 32'hAA22CC44, 4'b0000, 1'b0);
    wr_a(4'd3, 32'hFFFFFFFF, 4'b0000, 4'b0000);
    rd_a(4'd3, 32'hAA22CC44, 4'b0000, 1'b0);

    // 3: parity injection, counter increment, saturation, clear priority
    wr_a(4'd5, 32'h000000FF, 4'b0001, 4'b0001);
    rd_a(4'd5, 32'h000000FF, 4'b0001, 1'b0);
    chk("err_cnt_before_inc", rd_err_cnt, 0);
    step();
    chk("err_cnt_first", rd_err_cnt, 1);
    for (int i = 0; i < 300; i++) rd_a(4'd5, 32'h000000FF, 4'b0001, 1'b0);
    step();
    step();
    chk("err_cnt_saturated", rd_err_cnt, 255);
    rd_a(4'd5, 32'h000000FF, 4'b0001, 1'b0);
    rd_err_cnt_clr = 1'b1; rd_en = 1'b1; rd_addr = 4'd5;
    qa.push_back('{d: 32'h000000FF, pe: 4'b0001, ae: 1'b0, cy: cyc + 1});
    step();
    rd_err_cnt_clr = 1'b0; rd_en = 1'b0;
    chk("err_cnt_clr_wins", rd_err_cnt, 0);
    step();
    chk("err_cnt_after_clr", rd_err_cnt, 1);

    // 4: fill, then clear with a simultaneous write
    for (int i = 0; i < 16; i++) wr_a(4'(i), 32'h10000000 | 32'(i), 4'b1111, 4'b0000);
    rd_a(4'd9, 32'h10000009, 4'b0000, 1'b0);
    wr_clr = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_din = 32'hDEADBEEF; wr_be = 4'b1111;
    step();
    wr_clr = 1'b0; wr_en = 1'b0;
    chk("clr_wr_addr_err", wr_addr_err, 0);
    for (int i = 0; i < 16; i++) rd_a(4'(i), 32'h0, 4'h0, 1'b0);

    // 5: DEPTH=12 instance, combinational read, address range errors
    wr_b(4'd3, 32'h12345678, 4'b1111, 4'b0000);
    wr_b(4'd11, 32'hCAFEF00D, 4'b1111, 4'b0000);
    wr_b(4'd13, 32'hFFFFFFFF, 4'b1111, 4'b0000);
    chk("b_wr_addr_err_pulse", b_wr_addr_err, 1);
    step();
    chk("b_wr_addr_err_end", b_wr_addr_err, 0);
    rd_b(4'd3, 32'h12345678, 4'b0000, 1'b0);
    rd_b(4'd11, 32'hCAFEF00D, 4'b0000, 1'b0);
    rd_b(4'd13, 32'h0, 4'b0000, 1'b1);
    rd_b(4'd12, 32'h0, 4'b0000, 1'b1);
    rd_b(4'd1, 32'h0, 4'b0000, 1'b0);
    wr_b(4'd4, 32'h0F0F0F0F, 4'b1111, 4'b1010);
    rd_b(4'd4, 32'h0F0F0F0F, 4'b1010, 1'b0);
    chk("b_err_cnt", b_rd_err_cnt, 1);
    b_wr_clr = 1'b1; b_wr_en = 1'b1; b_wr_addr = 4'd13; b_wr_be = 4'b1111;
    step();
    b_wr_clr = 1'b0; b_wr_en = 1'b0;
    chk("b_clr_wr_addr_err", b_wr_addr_err, 0);
    rd_b(4'd3, 32'h0, 4'b0000, 1'b0);

    // 6: read-before-write on a shared clock, then reset mid-burst
    wr_a(4'd7, 32'h5, 4'b1111, 4'b0000);
    wr_en = 1'b1; wr_addr = 4'd7; wr_din = 32'h9; wr_be = 4'b1111;
    rd_en = 1'b1; rd_addr = 4'd7;
    qa.push_back('{d: 32'h5, pe: 4'b0000, ae: 1'b0, cy: cyc + 1});
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    rd_a(4'd7, 32'h9, 4'b0000, 1'b0);
    wr_a(4'd8, 32'h88, 4'b1111, 4'b0000);
    wr_en = 1'b1; wr_addr = 4'd9; wr_din = 32'h99; wr_be = 4'b1111;
    #2 wr_reset_n = 1'b0;
    step();
    wr_en = 1'b0; wr_reset_n = 1'b1;
    rd_a(4'd7, 32'h0, 4'b0000, 1'b0);
    rd_a(4'd8, 32'h0, 4'b0000, 1'b0);
    rd_a(4'd9, 32'h0, 4'b0000, 1'b0);

    step();
    step();
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
